// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_seq_pkg;

    // Sequencer states: wait for start, pulse operands, wait for result, publish
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_VEC_LEN     = 8;
    localparam int DEF_A_W         = 8;
    localparam int DEF_B_W         = 8;
    localparam int DEF_ACC_W       = 32;
    localparam int DEF_MAC_TIMEOUT = 64;
    localparam int IDX_W           = $clog2(DEF_VEC_LEN);

endpackage

// File: rtl/mac_dot_sequencer_operand_buffer.sv
// Dual-vector operand register file: one write port, one combinational read.
// A write to the address being read is forwarded so a load in the same
// cycle as the first read is seen by that read.
module operand_buffer #(
    parameter int VEC_LEN = 8,
    parameter int A_W     = 8,
    parameter int B_W     = 8
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(VEC_LEN)-1:0] wr_addr,
    input  logic [A_W-1:0]             wr_a,
    input  logic [B_W-1:0]             wr_b,
    input  logic [$clog2(VEC_LEN)-1:0] rd_addr,
    output logic [A_W-1:0]             rd_a,
    output logic [B_W-1:0]             rd_b
);

    logic [A_W-1:0] mem_a [VEC_LEN];
    logic [B_W-1:0] mem_b [VEC_LEN];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    // Read at the requested index with write-first forwarding
    always_comb begin
        rd_a = mem_a[rd_addr];
        rd_b = mem_b[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_a = wr_a;
            rd_b = wr_b;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Drives one fixed-point MAC through a VEC_LEN-element dot product, chaining
// each result back as the next c operand, and reports the final sum.
//
// MAC handshake: the MAC has no tready. a/b/c tvalid rise together for exactly
// one cycle (the ISSUE cycle) with registered tdata; a result is accepted only
// while in WAIT, on any cycle where s_axis_result_tvalid is high.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int VEC_LEN     = DEF_VEC_LEN,
    parameter int A_W         = DEF_A_W,
    parameter int B_W         = DEF_B_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int MAC_TIMEOUT = DEF_MAC_TIMEOUT
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       load_valid,
    input  logic [$clog2(VEC_LEN)-1:0] load_addr,
    input  logic [A_W-1:0]             load_a,
    input  logic [B_W-1:0]             load_b,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           dot_result,
    output logic                       timeout_err,
    output logic                       m_axis_a_tvalid,
    output logic [A_W-1:0]             m_axis_a_tdata,
    output logic                       m_axis_b_tvalid,
    output logic [B_W-1:0]             m_axis_b_tdata,
    output logic                       m_axis_c_tvalid,
    output logic [ACC_W-1:0]           m_axis_c_tdata,
    input  logic                       s_axis_result_tvalid,
    input  logic [ACC_W-1:0]           s_axis_result_tdata
);

    localparam int IW = $clog2(VEC_LEN);
    localparam int CW = $clog2(MAC_TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_next;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]   tmo_cnt;
    logic            start_ok;
    logic            load_ok;
    logic            res_ok;
    logic            last_elem;
    logic            tmo_hit;
    logic            issue_go;
    logic [A_W-1:0]  rd_a;
    logic [B_W-1:0]  rd_b;

    // Host requests are honoured only when fully idle (busy also covers the
    // cycle after done, so nothing sneaks in while the result is published)
    assign start_ok  = (state == IDLE) && start && !busy;
    assign load_ok   = (state == IDLE) && load_valid && !busy;
    assign res_ok    = (state == WAIT) && s_axis_result_tvalid;
    assign last_elem = (idx == IW'(VEC_LEN - 1));
    assign tmo_hit   = (state == WAIT) && !s_axis_result_tvalid &&
                       (tmo_cnt == CW'(MAC_TIMEOUT - 1));

    // Operands for the upcoming issue are read at the index the sequence moves to
    operand_buffer #(
        .VEC_LEN (VEC_LEN),
        .A_W     (A_W),
        .B_W     (B_W)
    ) u_buf (
        .clk     (aclk),
        .wr_en   (load_ok),
        .wr_addr (load_addr),
        .wr_a    (load_a),
        .wr_b    (load_b),
        .rd_addr (idx_next),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next index and the issue strobe
    always_comb begin
        state_next = state;
        idx_next   = idx;
        issue_go   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = ISSUE;
                    idx_next   = '0;
                    issue_go   = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (res_ok) begin
                    if (last_elem) begin
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                        idx_next   = idx + IW'(1);
                        issue_go   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand stream registers: one-cycle pulse, c is 0 first, then the chained result
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_a_tvalid <= 1'b0;
            m_axis_b_tvalid <= 1'b0;
            m_axis_c_tvalid <= 1'b0;
            m_axis_a_tdata  <= '0;
            m_axis_b_tdata  <= '0;
            m_axis_c_tdata  <= '0;
        end else begin
            m_axis_a_tvalid <= issue_go;
            m_axis_b_tvalid <= issue_go;
            m_axis_c_tvalid <= issue_go;
            if (issue_go) begin
                m_axis_a_tdata <= rd_a;
                m_axis_b_tdata <= rd_b;
                m_axis_c_tdata <= (state == IDLE) ? '0 : s_axis_result_tdata;
            end
        end
    end

    // Index, accumulator, timeout counter and host-facing status
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx         <= '0;
            acc         <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dot_result  <= '0;
            timeout_err <= 1'b0;
        end else begin
            idx  <= idx_next;
            done <= 1'b0;
            if (start_ok) begin
                busy        <= 1'b1;
                timeout_err <= 1'b0;
                acc         <= '0;
            end else if (state == IDLE) begin
                busy <= 1'b0;
            end
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (res_ok) begin
                acc <= s_axis_result_tdata;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
            end
            if (state == DONE) begin
                dot_result <= acc;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural MAC of configurable latency.
module tb_mac_dot_sequencer;

    localparam int VEC_LEN = 8;
    localparam int A_W     = 8;
    localparam int B_W     = 8;
    localparam int ACC_W   = 32;
    localparam int MAC_TO  = 64;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic             load_valid = 1'b0;
    logic [2:0]       load_addr = '0;
    logic [A_W-1:0]   load_a = '0;
    logic [B_W-1:0]   load_b = '0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] dot_result;
    logic             timeout_err;
    logic             m_axis_a_tvalid;
    logic [A_W-1:0]   m_axis_a_tdata;
    logic             m_axis_b_tvalid;
    logic [B_W-1:0]   m_axis_b_tdata;
    logic             m_axis_c_tvalid;
    logic [ACC_W-1:0] m_axis_c_tdata;
    logic             s_axis_result_tvalid;
    logic [ACC_W-1:0] s_axis_result_tdata;

    mac_dot_sequencer #(
        .VEC_LEN(VEC_LEN), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .MAC_TIMEOUT(MAC_TO)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .load_valid           (load_valid),
        .load_addr            (load_addr),
        .load_a               (load_a),
        .load_b               (load_b),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .dot_result           (dot_result),
        .timeout_err          (timeout_err),
        .m_axis_a_tvalid      (m_axis_a_tvalid),
        .m_axis_a_tdata       (m_axis_a_tdata),
        .m_axis_b_tvalid      (m_axis_b_tvalid),
        .m_axis_b_tdata       (m_axis_b_tdata),
        .m_axis_c_tvalid      (m_axis_c_tvalid),
        .m_axis_c_tdata       (m_axis_c_tdata),
        .s_axis_result_tvalid (s_axis_result_tvalid),
        .s_axis_result_tdata  (s_axis_result_tdata)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mac_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [31:0] c);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return c + 32'(sa * sb);
    endfunction

    // ---------------- behavioural MAC ----------------
    // Result appears mac_lat cycles after the cycle its operands are valid.
    int          mac_lat = 3;
    int          issue_cnt = 0;
    int          drop_n = -1;
    logic        spur_v = 1'b0;
    logic [31:0] spur_d = '0;
    logic        pipe_v [16];
    logic [31:0] pipe_d [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
    end

    always @(posedge aclk) begin
        for (int i = 15; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        pipe_v[0] <= m_axis_a_tvalid && (issue_cnt != drop_n);
        pipe_d[0] <= mac_fn(m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata);
        if (m_axis_a_tvalid) issue_cnt <= issue_cnt + 1;
    end

    assign s_axis_result_tvalid = pipe_v[mac_lat-1] | spur_v;
    assign s_axis_result_tdata  = spur_v ? spur_d : pipe_d[mac_lat-1];

    // ---------------- scoreboard ----------------
    logic [47:0] exp_q[$];   // {a, b, c} per expected operand pulse
    logic [31:0] res_q[$];   // expected dot_result per done pulse
    logic [7:0]  va [VEC_LEN];
    logic [7:0]  vb [VEC_LEN];

    always @(negedge aclk) begin
        logic [47:0] op;
        if (!areset) begin
            if (m_axis_a_tvalid || m_axis_b_tvalid || m_axis_c_tvalid) begin
                check_eq("tvalid_abc", {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid}, 3'b111);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_tvalid", m_axis_a_tvalid, 1'b0);
                end else begin
                    op = exp_q.pop_front();
                    check_eq("op_a", m_axis_a_tdata, op[47:40]);
                    check_eq("op_b", m_axis_b_tdata, op[39:32]);
                    check_eq("op_c", m_axis_c_tdata, op[31:0]);
                end
            end
            if (done) begin
                if (res_q.size() == 0) check_eq("spurious_done", done, 1'b0);
                else check_eq("dot_result", dot_result, res_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_vec(input logic [7:0] a0, input logic [7:0] a_step,
                            input logic [7:0] bval, input int n);
        for (int i = 0; i < VEC_LEN; i++) begin
            va[i] = a0 + 8'(i) * a_step;
            vb[i] = bval;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            load_valid = 1'b1;
            load_addr  = 3'(i);
            load_a     = va[i];
            load_b     = vb[i];
        end
        @(negedge aclk);
        load_valid = 1'b0;
    endtask

    // Runs one start; times done/timeout relative to the edge that samples start.
    task automatic run_dot(input string tag, input int lat, input int n_ops,
                           input int exp_done, input int exp_tmo, input int inj_cyc,
                           input int rst_cyc, input bit load_last, input int budget);
        logic [31:0] c;
        int done_at;
        int tmo_at;
        int busy_len;
        bit busy_run;
        mac_lat = lat;
        c = '0;
        for (int i = 0; i < n_ops; i++) begin
            exp_q.push_back({va[i], vb[i], c});
            c = mac_fn(va[i], vb[i], c);
        end
        if (exp_done >= 0) begin
            c = '0;
            for (int i = 0; i < VEC_LEN; i++) c = mac_fn(va[i], vb[i], c);
            res_q.push_back(c);
        end
        @(negedge aclk);
        start = 1'b1;
        if (load_last) begin
            load_valid = 1'b1;
            load_addr  = 3'(VEC_LEN - 1);
            load_a     = va[VEC_LEN-1];
            load_b     = vb[VEC_LEN-1];
        end
        @(negedge aclk);
        start      = 1'b0;
        load_valid = 1'b0;
        done_at  = -1;
        tmo_at   = -1;
        busy_len = 0;
        busy_run = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (busy_run && busy) busy_len++;
            else busy_run = 1'b0;
            if (done && done_at < 0) done_at = k;
            if (timeout_err && tmo_at < 0) tmo_at = k;
            if (k == 0) check_eq({tag, "_tmo_clr"}, timeout_err, 1'b0);
            if (k == inj_cyc) begin
                start = 1'b1; load_valid = 1'b1; load_addr = '0; load_a = 8'd99; load_b = 8'd99;
            end else begin
                start = 1'b0; load_valid = 1'b0;
            end
            if (k == rst_cyc) begin
                areset = 1'b1;
                #1;
                check_eq({tag, "_rst_outs"},
                         {busy, done, timeout_err, m_axis_a_tvalid, m_axis_b_tvalid,
                          m_axis_c_tvalid, |dot_result, |m_axis_a_tdata, |m_axis_b_tdata,
                          |m_axis_c_tdata}, 10'd0);
            end else begin
                areset = 1'b0;
            end
            @(negedge aclk);
        end
        areset = 1'b0;
        check_eq({tag, "_done_cyc"}, done_at, exp_done);
        check_eq({tag, "_tmo_cyc"}, tmo_at, exp_tmo);
        if (exp_done >= 0) check_eq({tag, "_busy_len"}, busy_len, exp_done + 1);
        if (exp_tmo >= 0) check_eq({tag, "_busy_len"}, busy_len, exp_tmo);
        check_eq({tag, "_ops_left"}, exp_q.size(), 0);
        check_eq({tag, "_res_left"}, res_q.size(), 0);
        exp_q.delete();
        res_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check_eq("rst_outs",
                 {busy, done, timeout_err, m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid,
                  |dot_result, |m_axis_a_tdata, |m_axis_b_tdata, |m_axis_c_tdata}, 10'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // positive vector a=1..8, b=1
        load_vec(8'd1, 8'd1, 8'd1, VEC_LEN);
        run_dot("pos_l3", 3, 8, 33, -1, -1, -1, 1'b0, 38);

        // signed all -1, last element loaded in the start cycle
        load_vec(8'hFF, 8'd0, 8'hFF, VEC_LEN - 1);
        run_dot("signed_l1", 1, 8, 17, -1, -1, -1, 1'b1, 22);

        // latency sweep
        load_vec(8'd1, 8'd1, 8'd1, VEC_LEN);
        run_dot("lat_l1", 1, 8, 17, -1, -1, -1, 1'b0, 22);
        run_dot("lat_l10", 10, 8, 89, -1, -1, -1, 1'b0, 94);

        // third result dropped -> timeout 64 cycles into the third WAIT
        drop_n = issue_cnt + 2;
        run_dot("tmo", 3, 3, -1, 73, -1, -1, 1'b0, 80);
        check_eq("tmo_dot_hold", dot_result, 32'd36);
        check_eq("tmo_busy", busy, 1'b0);
        drop_n = -1;
        run_dot("after_tmo", 3, 8, 33, -1, -1, -1, 1'b0, 38);

        // reset in the WAIT of element 4; the late result must be ignored
        run_dot("rst_mid", 3, 4, -1, -1, -1, 13, 1'b0, 30);
        check_eq("rst_dot", dot_result, 32'd0);
        check_eq("rst_busy", busy, 1'b0);
        load_vec(8'd1, 8'd1, 8'd1, VEC_LEN);
        run_dot("after_rst", 3, 8, 33, -1, -1, -1, 1'b0, 38);

        // start + load while busy, then a spurious result while idle
        run_dot("illegal", 3, 8, 33, -1, 5, -1, 1'b0, 38);
        @(negedge aclk);
        spur_v = 1'b1;
        spur_d = 32'd12345;
        @(negedge aclk);
        spur_v = 1'b0;
        repeat (4) @(negedge aclk);
        check_eq("spur_dot", dot_result, 32'd36);
        check_eq("spur_busy", busy, 1'b0);
        run_dot("buf_intact", 3, 8, 33, -1, -1, -1, 1'b0, 38);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
